// File: rtl/mpf_rd_stream_pkg.sv
// Shared types and helpers for the MPF read stream engine: FSM states,
// the c0 burst-length encoding and its decode to a line count.
package mpf_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] CL_LEN_1 = 2'd0;
  localparam logic [1:0] CL_LEN_2 = 2'd1;
  localparam logic [1:0] CL_LEN_4 = 2'd3;

  function automatic logic [2:0] burst_lines(input logic [1:0] len);
    case (len)
      CL_LEN_2: burst_lines = 3'd2;
      CL_LEN_4: burst_lines = 3'd4;
      default:  burst_lines = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mpf_rd_burst_sel.sv
// Picks the largest naturally aligned burst that fits the remaining line
// count, capped by MAX_BURST.
module mpf_rd_burst_sel
  import mpf_rd_stream_pkg::*;
#(
  parameter int LEN_W     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic [1:0]       addr_lsb,
  input  logic [LEN_W-1:0] rem,
  output logic [1:0]       cl_len
);

  always_comb begin
    cl_len = CL_LEN_1;
    if ((MAX_BURST >= 4) && (addr_lsb == 2'b00) && (rem >= LEN_W'(4))) begin
      cl_len = CL_LEN_4;
    end else if ((MAX_BURST >= 2) && (addr_lsb[0] == 1'b0) && (rem >= LEN_W'(2))) begin
      cl_len = CL_LEN_2;
    end
  end

endmodule

// File: rtl/mpf_rd_stream_engine.sv
// Streams a contiguous region of cache lines from host memory with aligned
// 1/2/4-line bursts, credit and rate limiting, abort, and tagged buffer writes.
module mpf_rd_stream_engine
  import mpf_rd_stream_pkg::*;
#(
  parameter int CL_ADDR_W       = 42,
  parameter int LEN_W           = 32,
  parameter int MAX_BURST       = 4,
  parameter int MAX_OUTSTANDING = 32,
  parameter int MDATA_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 abort,
  input  logic [CL_ADDR_W-1:0] first_clAddr,
  input  logic [LEN_W-1:0]     data_length,
  input  logic [3:0]           req_interval,
  input  logic [LEN_W-1:0]     buf_space,
  input  logic                 c0TxAlmFull,
  output logic                 req_valid,
  output logic [CL_ADDR_W-1:0] req_clAddr,
  output logic [1:0]           req_cl_len,
  output logic [MDATA_W-1:0]   req_mdata,
  input  logic                 rsp_valid,
  input  logic [MDATA_W-1:0]   rsp_mdata,
  input  logic [1:0]           rsp_cl_num,
  output logic                 buf_wr_en,
  output logic [MDATA_W-1:0]   buf_wr_offset,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 rsp_err
);

  state_t                 state_reg, state_next;
  logic [CL_ADDR_W-1:0]   addr_reg, addr_next;
  logic [LEN_W-1:0]       issued_reg, issued_next;
  logic [LEN_W-1:0]       outstanding_reg, outstanding_next;
  logic [3:0]             thr_reg, thr_next;
  logic                   req_valid_reg, req_valid_next;
  logic [CL_ADDR_W-1:0]   req_addr_reg, req_addr_next;
  logic [1:0]             req_len_reg, req_len_next;
  logic [MDATA_W-1:0]     req_mdata_reg, req_mdata_next;
  logic                   done_reg, done_next;
  logic                   aborted_reg, aborted_next;
  logic                   rsp_err_reg, rsp_err_next;

  logic [LEN_W-1:0]       rem;
  logic [1:0]             burst_len;
  logic [2:0]             burst;
  logic [LEN_W:0]         credit_need;
  logic                   credit_ok;
  logic                   issue;
  logic                   rsp_stray;

  assign rem = data_length - issued_reg;

  mpf_rd_burst_sel #(
    .LEN_W     (LEN_W),
    .MAX_BURST (MAX_BURST)
  ) u_burst_sel (
    .addr_lsb (addr_reg[1:0]),
    .rem      (rem),
    .cl_len   (burst_len)
  );

  assign burst = burst_lines(burst_len);

  // One extra bit so the credit sum cannot wrap against a large buf_space.
  assign credit_need = {1'b0, outstanding_reg} + (LEN_W+1)'(burst);
  assign credit_ok   = (credit_need <= (LEN_W+1)'(MAX_OUTSTANDING)) &&
                       (credit_need <= {1'b0, buf_space});

  assign issue = (state_reg == RUN) && !abort && (rem != '0) && !c0TxAlmFull &&
                 (thr_reg >= req_interval) && credit_ok;

  assign rsp_stray = rsp_valid && (outstanding_reg == '0);

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    issued_next      = issued_reg;
    req_valid_next   = issue;
    req_addr_next    = req_addr_reg;
    req_len_next     = req_len_reg;
    req_mdata_next   = req_mdata_reg;
    done_next        = 1'b0;
    aborted_next     = aborted_reg;
    rsp_err_next     = rsp_err_reg;
    thr_next         = issue ? 4'd0 : ((thr_reg == 4'hF) ? 4'hF : thr_reg + 4'd1);
    outstanding_next = outstanding_reg
                     + (issue ? LEN_W'(burst) : LEN_W'(0))
                     - ((rsp_valid && !rsp_stray) ? LEN_W'(1) : LEN_W'(0));

    if (issue) begin
      req_addr_next  = addr_reg;
      req_len_next   = burst_len;
      req_mdata_next = MDATA_W'(issued_reg);
    end

    case (state_reg)
      IDLE: begin
        if (run) begin
          aborted_next = 1'b0;
          rsp_err_next = 1'b0;
          addr_next    = first_clAddr;
          issued_next  = '0;
          if (data_length != '0) state_next = RUN;
          else                   done_next  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = DRAIN;
        end else if (issue) begin
          addr_next   = addr_reg + CL_ADDR_W'(burst);
          issued_next = issued_reg + LEN_W'(burst);
          if (LEN_W'(burst) == rem) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((outstanding_reg == '0) && !rsp_valid) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A stray response is flagged even on the cycle a new run clears the flag.
    if (rsp_stray) rsp_err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      issued_reg      <= '0;
      outstanding_reg <= '0;
      thr_reg         <= '0;
      req_valid_reg   <= 1'b0;
      req_addr_reg    <= '0;
      req_len_reg     <= '0;
      req_mdata_reg   <= '0;
      done_reg        <= 1'b0;
      aborted_reg     <= 1'b0;
      rsp_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      issued_reg      <= issued_next;
      outstanding_reg <= outstanding_next;
      thr_reg         <= thr_next;
      req_valid_reg   <= req_valid_next;
      req_addr_reg    <= req_addr_next;
      req_len_reg     <= req_len_next;
      req_mdata_reg   <= req_mdata_next;
      done_reg        <= done_next;
      aborted_reg     <= aborted_next;
      rsp_err_reg     <= rsp_err_next;
    end
  end

  assign req_valid     = req_valid_reg;
  assign req_clAddr    = req_addr_reg;
  assign req_cl_len    = req_len_reg;
  assign req_mdata     = req_mdata_reg;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign aborted       = aborted_reg;
  assign rsp_err       = rsp_err_reg;
  assign buf_wr_en     = rsp_valid && busy;
  assign buf_wr_offset = rsp_mdata + MDATA_W'(rsp_cl_num);

endmodule
